// File: rtl/cdc_hs_arbiter.sv
// Round-robin arbiter driving a 4-phase req/ack handshake into another clock
// domain, with a per-transfer ack timeout.
module cdc_hs_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int TMO  = 255,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic              clk_source,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic              cdc_req,
  output logic [DW-1:0]     cdc_data,
  output logic [IW-1:0]     cdc_id,
  input  logic              cdc_ack,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ_HI = 2'd1;
  localparam logic [1:0] S_REQ_LO = 2'd2;
  localparam logic [1:0] S_ERR_LO = 2'd3;

  localparam logic [7:0]      TMO8 = 8'(TMO);
  localparam logic [NREQ-1:0] ONE  = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0]   LAST = IW'(NREQ - 1);

  logic [1:0]    state;
  logic [7:0]    cnt;
  logic          ack_m;
  logic          ack_s;
  logic [IW-1:0] last_grant;

  logic          gnt_ok;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] j;
  logic [DW-1:0] gnt_data;

  always_ff @(posedge clk_source or negedge rst_n) begin
    if (!rst_n) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= cdc_ack;
      ack_s <= ack_m;
    end
  end

  // Scan downward so the nearest requester above last_grant is written last.
  always_comb begin
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    j       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = IW'((32'(last_grant) + 32'(k)) % 32'(NREQ));
      if (req_valid[j]) begin
        gnt_ok  = 1'b1;
        gnt_idx = j;
      end
    end
  end

  always_comb begin
    gnt_data = req_data[32'(gnt_idx)*DW +: DW];
  end

  always_ff @(posedge clk_source or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cdc_req    <= 1'b0;
      cdc_data   <= '0;
      cdc_id     <= '0;
      done       <= '0;
      err        <= '0;
      last_grant <= LAST;
    end else begin
      done <= '0;
      err  <= '0;
      unique case (state)
        S_IDLE: begin
          if (gnt_ok) begin
            cdc_req  <= 1'b1;
            cdc_data <= gnt_data;
            cdc_id   <= gnt_idx;
            cnt      <= '0;
            state    <= S_REQ_HI;
          end
        end
        S_REQ_HI: begin
          if (ack_s) begin
            cdc_req <= 1'b0;
            state   <= S_REQ_LO;
          end else if (cnt == TMO8) begin
            cdc_req <= 1'b0;
            err     <= ONE << cdc_id;
            state   <= S_ERR_LO;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_REQ_LO: begin
          if (!ack_s) begin
            done       <= ONE << cdc_id;
            last_grant <= cdc_id;
            state      <= S_IDLE;
          end
        end
        S_ERR_LO: begin
          if (!ack_s) begin
            last_grant <= cdc_id;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// Directed bench for cdc_hs_arbiter: single, round-robin, min latency,
// timeout, late ack, ack/timeout tie and reset mid-transfer.
module tb_cdc_hs_arbiter;

  logic        clk_source = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  done;
  logic [3:0]  err;
  logic        cdc_req;
  logic [7:0]  cdc_data;
  logic [1:0]  cdc_id;
  logic        cdc_ack;
  logic        busy;

  int          checks = 0;
  int          failures = 0;
  int          mode = 0;
  logic        ack_man = 1'b0;
  logic [2:0]  dly = '0;

  logic [3:0]  d;
  logic [3:0]  e;
  int          n;
  int          hi;

  cdc_hs_arbiter #(.NREQ(4), .DW(8), .TMO(15)) dut (
    .clk_source(clk_source),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .done(done),
    .err(err),
    .cdc_req(cdc_req),
    .cdc_data(cdc_data),
    .cdc_id(cdc_id),
    .cdc_ack(cdc_ack),
    .busy(busy)
  );

  always #5 clk_source = ~clk_source;

  // Target-domain model: 3-stage loopback, direct loopback or manual level.
  always @(posedge clk_source) dly <= {dly[1:0], cdc_req};
  assign cdc_ack = (mode == 1) ? dly[2] :
                   (mode == 2) ? cdc_req : ack_man;

  task automatic tick(input int k);
    repeat (k) @(posedge clk_source);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rise(input string tag);
    int c;
    c = 0;
    while (cdc_req !== 1'b1 && c < 200) begin
      tick(1);
      c++;
    end
    chk(tag, 32'(cdc_req), 32'd1);
  endtask

  task automatic wait_done(output logic [3:0] dd, output logic [3:0] ee,
                           output int nn);
    nn = 0;
    dd = '0;
    ee = '0;
    while (nn < 300) begin
      tick(1);
      nn++;
      if (done != 4'd0 || err != 4'd0) begin
        dd = done;
        ee = err;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    logic [1:0] exp_id;
    tick(2);
    chk("rst_cdc_req", 32'(cdc_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_id", 32'(cdc_id), 0);
    chk("rst_data", 32'(cdc_data), 0);
    rst_n = 1'b1;
    tick(1);

    // Single transfer
    mode = 1;
    req_data = 32'h0000_00A5;
    req_valid = 4'b0001;
    tick(1);
    chk("single_req", 32'(cdc_req), 1);
    chk("single_data", 32'(cdc_data), 32'hA5);
    chk("single_id", 32'(cdc_id), 0);
    chk("single_busy", 32'(busy), 1);
    wait_done(d, e, n);
    chk("single_done", 32'(d), 32'b0001);
    chk("single_err", 32'(e), 0);
    req_valid = 4'b0000;
    tick(1);
    chk("single_done_1cy", 32'(done), 0);
    chk("single_idle", 32'(busy), 0);
    chk("single_hold", 32'(cdc_data), 32'hA5);
    tick(4);

    // Round robin from reset
    do_reset();
    req_data = 32'h4433_2211;
    req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_id = 2'(t % 4);
      if (t == 0) begin
        wait_rise("rr_rise0");
      end else begin
        tick(1);
        chk("rr_b2b_rise", 32'(cdc_req), 1);
        chk("rr_done_clr", 32'(done), 0);
      end
      chk("rr_id", 32'(cdc_id), 32'(exp_id));
      chk("rr_data", 32'(cdc_data), 32'(8'h11 + 8'h11 * 8'(exp_id)));
      wait_done(d, e, n);
      chk("rr_done", 32'(d), 32'(4'b0001 << exp_id));
      chk("rr_err", 32'(e), 0);
    end
    req_valid = 4'b0000;
    tick(4);

    // Minimum latency with instant ack; requester drops mid-transfer
    mode = 2;
    req_data = 32'h0000_005A;
    req_valid = 4'b0001;
    wait_rise("min_rise");
    req_valid = 4'b0000;
    wait_done(d, e, n);
    chk("min_latency", 32'(n), 6);
    chk("min_done", 32'(d), 32'b0001);
    tick(4);

    // Timeout
    mode = 0;
    ack_man = 1'b0;
    req_data = 32'h00C3_0000;
    req_valid = 4'b0100;
    wait_rise("tmo_rise");
    chk("tmo_id", 32'(cdc_id), 2);
    chk("tmo_data", 32'(cdc_data), 32'hC3);
    hi = 1;
    while (cdc_req === 1'b1 && hi < 100) begin
      tick(1);
      if (cdc_req === 1'b1) hi++;
    end
    chk("tmo_hi_cycles", 32'(hi), 16);
    chk("tmo_err", 32'(err), 32'b0100);
    chk("tmo_no_done", 32'(done), 0);
    req_valid = 4'b0000;
    tick(1);
    chk("tmo_err_1cy", 32'(err), 0);
    chk("tmo_idle", 32'(busy), 0);
    tick(4);

    // Late ack arriving as the timeout fires
    req_valid = 4'b0100;
    wait_rise("late_rise");
    tick(14);
    ack_man = 1'b1;
    tick(2);
    chk("late_err", 32'(err), 32'b0100);
    chk("late_req_lo", 32'(cdc_req), 0);
    req_valid = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (i == 2) ack_man = 1'b0;
      chk("late_errlo_busy", 32'(busy), 1);
      chk("late_no_done", 32'(done | err), 0);
    end
    tick(1);
    chk("late_idle", 32'(busy), 0);
    chk("late_done", 32'(done), 0);
    tick(4);

    // ack_s rises the same cycle the counter reaches TMO
    req_valid = 4'b0100;
    wait_rise("tie_rise");
    tick(13);
    ack_man = 1'b1;
    tick(3);
    chk("tie_req_lo", 32'(cdc_req), 0);
    chk("tie_no_err", 32'(err), 0);
    chk("tie_busy", 32'(busy), 1);
    ack_man = 1'b0;
    req_valid = 4'b0000;
    wait_done(d, e, n);
    chk("tie_done", 32'(d), 32'b0100);
    chk("tie_err", 32'(e), 0);
    tick(4);

    // Reset during REQ_HI
    req_valid = 4'b0010;
    wait_rise("rst_rise");
    chk("rst_pre_id", 32'(cdc_id), 1);
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(cdc_req), 0);
    chk("midrst_busy", 32'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("midrst_quiet", 32'(done | err), 0);
    end
    mode = 1;
    req_valid = 4'b1111;
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_req", 32'(cdc_req), 1);
    chk("post_rst_id", 32'(cdc_id), 0);
    wait_done(d, e, n);
    chk("post_rst_done", 32'(d), 32'b0001);
    req_valid = 4'b0000;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdc_hs_arbiter.md
CDC_HS_ARBITER -- requirements
Module: cdc_hs_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of source-domain requesters (range 2..8).
REQ-002 Parameter DW, default 8, SHALL set the payload width per requester.
REQ-003 Parameter TMO, default 255, SHALL set the ack-wait timeout in clk_source cycles (8-bit counter).
REQ-004 clk_source  input  1  SHALL be the sole clock; all state is clocked on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 req_valid  input  NREQ  SHALL carry one level request per requester, held until its done or err pulse.
REQ-007 req_data  input  NREQ*DW  SHALL carry the payloads; requester i owns bits [i*DW +: DW], held stable while req_valid[i]=1.
REQ-008 done  output  NREQ  SHALL pulse for one cycle on bit i when requester i's transfer completes.
REQ-009 err  output  NREQ  SHALL pulse for one cycle on bit i when requester i's transfer times out.
REQ-010 cdc_req  output  1  SHALL be the 4-phase request level, registered, sent to the target domain through a 3-stage synchronizer chain.
REQ-011 cdc_data  output  DW  SHALL be the registered payload, stable for the entire time cdc_req=1.
REQ-012 cdc_id  output  clog2(NREQ)  SHALL be the registered index of the granted requester, stable with cdc_data.
REQ-013 cdc_ack  input  1  SHALL be the raw acknowledge level from the target domain, asynchronous to clk_source.
REQ-014 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-015 cdc_ack SHALL be synchronized internally by two clk_source flops (reset 0) to give ack_s; no logic SHALL use the raw cdc_ack.
REQ-016 FSM states SHALL be IDLE, REQ_HI, REQ_LO, ERR_LO.
REQ-017 IDLE: if any req_valid bit is set, grant SHALL go to the first set bit searching upward (with wrap) from last_grant+1 mod NREQ; on the next edge cdc_req=1, cdc_data/cdc_id latch the winner, timeout counter clears, state -> REQ_HI.
REQ-018 IDLE with no request pending: state, cdc_req, cdc_data, cdc_id SHALL hold.
REQ-019 REQ_HI: on ack_s=1, cdc_req SHALL drop to 0 next edge, state -> REQ_LO; otherwise the counter increments by 1 each cycle.
REQ-020 REQ_HI: when the counter equals TMO and ack_s=0, cdc_req SHALL drop, err[cdc_id] SHALL pulse one cycle, state -> ERR_LO.
REQ-021 If ack_s=1 in the same cycle the counter reaches TMO, the ack SHALL win (no error; normal path).
REQ-022 REQ_LO: on ack_s=0, done[cdc_id] SHALL pulse one cycle, last_grant <= cdc_id, state -> IDLE.
REQ-023 ERR_LO: on ack_s=0, last_grant <= cdc_id, state -> IDLE; no done pulse. A late ack rising in ERR_LO SHALL be waited out (stay until ack_s=0).
REQ-024 done and err SHALL be one-hot or zero and never both nonzero in a cycle.
REQ-025 A requester dropping req_valid mid-transfer SHALL NOT abort the handshake; its done/err still pulses.
REQ-026 Back-to-back: the earliest next cdc_req rise SHALL be the cycle after the done pulse (IDLE lasts at least 1 cycle).
REQ-027 Minimum transfer, ack returning instantly, SHALL take 6 cycles from cdc_req rise to done pulse (2 sync + 1 FSM, each phase).
REQ-028 Round-robin SHALL guarantee that any held request is granted within NREQ transfers.

Reset
REQ-029 On rst_n=0, asynchronously: state=IDLE, cdc_req=0, cdc_data=0, cdc_id=0, done=0, err=0, busy=0, counter=0, both sync flops=0, last_grant=NREQ-1 (so requester 0 wins first).
REQ-030 Reset mid-transfer SHALL abandon the transfer with no done/err pulse; after release the FSM starts from IDLE.

Verification
REQ-031 Single: req_valid=0001, data0=0xA5, ack looped back through 3-stage delay -> cdc_req rises, cdc_data=0xA5, cdc_id=0, done=0001 one cycle, busy low afterward.
REQ-032 Round-robin: req_valid=1111 held, looped ack -> grant order 0,1,2,3,0 and done pulses in that order.
REQ-033 Timeout: TMO=15, req_valid=0100, cdc_ack tied 0 -> cdc_req high 16 cycles, err=0100 one cycle, no done, back to IDLE.
REQ-034 Late ack: timeout as above, then cdc_ack pulsed high 5 cycles inside ERR_LO -> FSM stays ERR_LO until ack_s=0, then IDLE, no done.
REQ-035 Tie: ack_s rises the same cycle the counter hits TMO -> normal REQ_LO path, done pulses, err stays 0.
REQ-036 Reset mid-op: assert rst_n=0 while in REQ_HI -> cdc_req=0, busy=0 immediately; no done/err; next grant goes to requester 0.
